psum_collector: RTL and testbench

Sits below the bottom row of the weight-stationary systolic array and drains the partial-sum chain leaving each column. Bottom-row column outputs arrive skewed by one cycle per column. The block times each column's sample from a single START pulse, deskews the columns into aligned row vectors and buffers them in a small FIFO. It presents the vectors on a valid/ready stream to the output writer, and flags overflow because the array itself cannot stall.

---
 rtl/psum_collector_pkg.sv | 15 +
 rtl/psum_fifo.sv | 98 +++++++++
 rtl/psum_collector.sv | 165 ++++++++++++++++
 tb/tb_psum_collector.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_collector_pkg.sv
// Shared definitions for the systolic-array output path: default geometry
// and the collector's run-state encoding.
package psum_collector_pkg;

  localparam int COLUMNS_DEFAULT     = 4;
  localparam int ACC_WIDTH_DEFAULT   = 32;
  localparam int COUNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO with a registered head word. Push while full succeeds only
// together with a pop; the drop policy itself is decided by the parent.
module psum_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             ASYNC_RST,
  input  logic             SYNC_RST,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] head_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_next_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Handshake qualification and next occupancy
  always_comb begin
    do_pop_s    = pop && !empty_r;
    do_push_s   = push && (!full_r || do_pop_s);
    rd_next_s   = rd_ptr_r + AW'(1'b1);
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array, written at the tail
  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, flags and the registered head word
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      head_r   <= '0;
    end else if (SYNC_RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      head_r   <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      empty_r <= (count_nxt_s == CW'(1'b0));
      // Head follows the next-oldest entry, or the incoming word when that is the only one
      if (do_pop_s) begin
        if (count_r > CW'(1'b1)) begin
          head_r <= mem_r[rd_next_s];
        end else if (do_push_s) begin
          head_r <= wdata;
        end else begin
          head_r <= '0;
        end
      end else if (do_push_s && empty_r) begin
        head_r <= wdata;
      end
    end
  end

  assign head  = head_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/psum_collector.sv
// Drains the skewed bottom-row partial sums of the systolic array, realigns
// them into row vectors and streams them out through a small FIFO.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int COLUMNS                = COLUMNS_DEFAULT,
  parameter int ACCUMULATOR_DATA_WIDTH = ACC_WIDTH_DEFAULT,
  parameter int LATENCY                = 4,
  parameter int COUNT_WIDTH            = COUNT_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                                      CLK,
  input  logic                                      ASYNC_RST,
  input  logic                                      SYNC_RST,
  input  logic                                      START,
  input  logic [COUNT_WIDTH-1:0]                    VECTOR_COUNT,
  input  logic [COLUMNS*ACCUMULATOR_DATA_WIDTH-1:0] PsumIn,
  output logic [COLUMNS*ACCUMULATOR_DATA_WIDTH-1:0] OutData,
  output logic                                      OutValid,
  input  logic                                      OutReady,
  output logic                                      Busy,
  output logic                                      Done,
  output logic                                      Overflow
);

  localparam int W          = ACCUMULATOR_DATA_WIDTH;
  localparam int PW         = COLUMNS * W;
  localparam int TOKEN_LEN  = LATENCY + COLUMNS - 1;
  // The ISSUE cycle itself is the first stage of the token line
  localparam int TOKEN_REGS = TOKEN_LEN - 1;
  localparam logic [TOKEN_REGS-1:0] TAIL_MASK = ~(TOKEN_REGS'(1'b1) << (TOKEN_REGS - 1));

  state_e                 state_r;
  logic [COUNT_WIDTH-1:0] remain_r;
  logic [TOKEN_REGS-1:0]  token_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   overflow_r;
  logic                   issue_s;
  logic                   start_ok_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [PW-1:0]          aligned_s;

  assign issue_s    = (state_r == ISSUE);
  assign start_ok_s = START && !busy_r && (state_r == IDLE);
  assign push_s     = token_r[TOKEN_REGS-1];
  assign pop_s      = !fifo_empty_s && OutReady;

  // Deskew: column c is delayed COLUMNS-1-c cycles so all lanes land together
  for (genvar c = 0; c < COLUMNS; c++) begin : g_lane
    if (c == COLUMNS - 1) begin : g_direct
      assign aligned_s[c*W +: W] = PsumIn[c*W +: W];
    end else begin : g_delay
      localparam int D = COLUMNS - 1 - c;
      logic [W-1:0] dly_r [D];

      // Per-column delay line
      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          for (int i = 0; i < D; i++) dly_r[i] <= '0;
        end else if (SYNC_RST) begin
          for (int i = 0; i < D; i++) dly_r[i] <= '0;
        end else begin
          dly_r[0] <= PsumIn[c*W +: W];
          for (int i = 1; i < D; i++) dly_r[i] <= dly_r[i-1];
        end
      end

      assign aligned_s[c*W +: W] = dly_r[D-1];
    end
  end

  // Token line marks which cycles carry a complete aligned vector
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      token_r <= '0;
    end else if (SYNC_RST) begin
      token_r <= '0;
    end else begin
      token_r <= (token_r << 1) | TOKEN_REGS'(issue_s);
    end
  end

  // Run control, status flags and overflow tracking
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_r    <= IDLE;
      remain_r   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (SYNC_RST) begin
      state_r    <= IDLE;
      remain_r   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          busy_r <= 1'b0;
          if (start_ok_s) begin
            busy_r     <= 1'b1;
            overflow_r <= 1'b0;
            remain_r   <= VECTOR_COUNT;
            if (VECTOR_COUNT == COUNT_WIDTH'(1'b0)) begin
              done_r  <= 1'b1;
              state_r <= FLUSH;
            end else begin
              state_r <= ISSUE;
            end
          end
        end
        ISSUE: begin
          remain_r <= remain_r - COUNT_WIDTH'(1'b1);
          if (remain_r == COUNT_WIDTH'(1'b1)) begin
            state_r <= FLUSH;
          end
        end
        FLUSH: begin
          // An empty run already pulsed Done on entry; otherwise finish as the last token is written
          if (done_r) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if ((token_r & TAIL_MASK) == TOKEN_REGS'(1'b0)) begin
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  psum_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .ASYNC_RST (ASYNC_RST),
    .SYNC_RST  (SYNC_RST),
    .push      (push_s),
    .wdata     (aligned_s),
    .pop       (pop_s),
    .head      (OutData),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign OutValid = !fifo_empty_s;
  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Overflow = overflow_r;

endmodule

// File: tb/tb_psum_collector.sv
// Randomized bench for psum_collector: a schedule-level reference model fills
// a scoreboard queue that a negedge monitor checks against the DUT stream.
module tb_psum_collector;

  localparam int COLUMNS = 4;
  localparam int W       = 32;
  localparam int LATENCY = 4;
  localparam int CW      = 16;
  localparam int DEPTH   = 4;
  localparam int PW      = COLUMNS * W;
  localparam int L       = LATENCY + COLUMNS - 1;

  logic          CLK = 1'b0;
  logic          ASYNC_RST;
  logic          SYNC_RST;
  logic          START;
  logic [CW-1:0] VECTOR_COUNT;
  logic [PW-1:0] PsumIn;
  logic [PW-1:0] OutData;
  logic          OutValid;
  logic          OutReady;
  logic          Busy;
  logic          Done;
  logic          Overflow;

  int checks = 0;
  int passes = 0;

  psum_collector #(
    .COLUMNS(COLUMNS), .ACCUMULATOR_DATA_WIDTH(W), .LATENCY(LATENCY),
    .COUNT_WIDTH(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .START(START),
    .VECTOR_COUNT(VECTOR_COUNT), .PsumIn(PsumIn), .OutData(OutData),
    .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy), .Done(Done),
    .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model state: input history per edge plus the active run's schedule
  logic [PW-1:0] hist [0:8191];
  logic [PW-1:0] exp_q [$];
  int  edge_n   = 0;
  bit  run_on   = 1'b0;
  int  run_e0   = 0;
  int  run_n    = 0;
  int  run_done = 0;
  bit  ov_m     = 1'b0;
  int  hs_count = 0;
  int  done_count = 0;
  bit  rand_ready = 1'b0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
  endtask

  function automatic bit busy_at(int e);
    return run_on && (e >= run_e0) && (e <= run_done);
  endfunction

  function automatic logic [PW-1:0] vector_k(int k);
    logic [PW-1:0] v;
    logic [PW-1:0] s;
    v = '0;
    for (int c = 0; c < COLUMNS; c++) begin
      s = hist[(run_e0 + LATENCY + c + k) & 8191];
      v[c*W +: W] = s[c*W +: W];
    end
    return v;
  endfunction

  task automatic model_clear();
    run_on = 1'b0;
    ov_m   = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: compare outputs after the last edge, then advance the model over the next edge
  always @(negedge CLK) begin
    bit pop_m;
    bit was_full;
    int k;
    if (!ASYNC_RST) begin
      model_clear();
      chk("reset_outdata", OutData, '0);
    end
    chk("outvalid", PW'(OutValid), PW'(exp_q.size() != 0));
    chk("busy", PW'(Busy), PW'(busy_at(edge_n)));
    chk("done", PW'(Done), PW'(run_on && edge_n == run_done));
    chk("overflow", PW'(Overflow), PW'(ov_m));
    if (OutValid && OutReady) hs_count++;
    if (Done) done_count++;

    edge_n++;
    hist[edge_n & 8191] = PsumIn;
    if (!ASYNC_RST || SYNC_RST) begin
      model_clear();
    end else begin
      pop_m    = (exp_q.size() != 0) && OutReady;
      was_full = (exp_q.size() == DEPTH);
      if (pop_m) begin
        chk("outdata", OutData, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (run_on && run_n > 0 && edge_n >= run_e0 + L && edge_n <= run_e0 + L + run_n - 1) begin
        k = edge_n - run_e0 - L;
        if (was_full && !pop_m) ov_m = 1'b1;
        else exp_q.push_back(vector_k(k));
      end
      if (START && !busy_at(edge_n - 1)) begin
        run_on   = 1'b1;
        run_e0   = edge_n;
        run_n    = int'(VECTOR_COUNT);
        run_done = (run_n == 0) ? edge_n : edge_n + L + run_n - 1;
        ov_m     = 1'b0;
      end
    end
  end

  function automatic logic [PW-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      PsumIn = rand_vec();
      START  = 1'b0;
      if (rand_ready) OutReady = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_run(int n);
    VECTOR_COUNT = CW'(n);
    START = 1'b1;
    step(1);
  endtask

  // Drives lane c with 100*k+c exactly at its sampling edge E0+LATENCY+c+k
  task automatic pattern_run(int n);
    logic [W-1:0] lane;
    start_run(n);
    for (int rel = 1; rel <= 14; rel++) begin
      for (int c = 0; c < COLUMNS; c++) begin
        lane = W'(100 * (rel - LATENCY - c) + c);
        PsumIn[c*W +: W] = lane;
      end
      @(posedge CLK);
      #1;
    end
    step(2);
  endtask

  initial begin
    int hs0;
    int dn0;
    ASYNC_RST = 1'b0; SYNC_RST = 1'b0; START = 1'b0; OutReady = 1'b1;
    VECTOR_COUNT = '0; PsumIn = '0;
    step(3);
    ASYNC_RST = 1'b1;
    step(2);

    // Basic aligned collection
    hs0 = hs_count; dn0 = done_count;
    pattern_run(2);
    chk("s1_vectors", PW'(hs_count - hs0), PW'(2));
    chk("s1_done", PW'(done_count - dn0), PW'(1));

    // Empty run
    hs0 = hs_count; dn0 = done_count;
    start_run(0);
    step(5);
    chk("s2_vectors", PW'(hs_count - hs0), PW'(0));
    chk("s2_done", PW'(done_count - dn0), PW'(1));

    // Overflow with a stalled consumer, then drain
    OutReady = 1'b0;
    hs0 = hs_count;
    start_run(6);
    step(16);
    chk("s3_overflow", PW'(Overflow), PW'(1));
    OutReady = 1'b1;
    step(8);
    chk("s3_drained", PW'(hs_count - hs0), PW'(4));

    // Push into a full FIFO with a simultaneous pop
    OutReady = 1'b0;
    hs0 = hs_count;
    start_run(8);
    step(10);
    OutReady = 1'b1;
    step(16);
    chk("s4_vectors", PW'(hs_count - hs0), PW'(8));
    chk("s4_overflow", PW'(Overflow), PW'(0));

    // START while busy is ignored
    hs0 = hs_count; dn0 = done_count;
    start_run(3);
    step(1);
    VECTOR_COUNT = CW'(7);
    START = 1'b1;
    step(1);
    step(16);
    chk("s5_vectors", PW'(hs_count - hs0), PW'(3));
    chk("s5_done", PW'(done_count - dn0), PW'(1));

    // Async abort mid-ISSUE, then sync abort in a second run
    dn0 = done_count; hs0 = hs_count;
    start_run(5);
    step(2);
    ASYNC_RST = 1'b0;
    #1;
    chk("s6_async_busy", PW'(Busy), PW'(0));
    step(2);
    ASYNC_RST = 1'b1;
    step(3);
    start_run(4);
    step(4);
    SYNC_RST = 1'b1;
    step(1);
    SYNC_RST = 1'b0;
    step(14);
    chk("s6_no_done", PW'(done_count - dn0), PW'(0));
    chk("s6_no_vectors", PW'(hs_count - hs0), PW'(0));
    hs0 = hs_count;
    pattern_run(2);
    chk("s6_restart", PW'(hs_count - hs0), PW'(2));

    // Randomized runs with random back-pressure and stray START pulses
    rand_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      start_run($urandom_range(0, 9));
      for (int i = 0; i < 24; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          START = 1'b1;
          VECTOR_COUNT = CW'($urandom_range(0, 9));
        end
        @(posedge CLK);
        #1;
        PsumIn = rand_vec();
        START  = 1'b0;
        OutReady = 1'($urandom_range(0, 1));
      end
    end
    rand_ready = 1'b0;
    OutReady = 1'b1;
    step(30);
    chk("final_empty", PW'(OutValid), PW'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
